dma_event_pacer: RTL and testbench

//  Source-domain (100 MHz) event queue and pacer feeding the DMAC's toggle-based pulse synchronizer.
//  - Counts incoming single-cycle event requests.
//  - Re-issues them as single-cycle pulses on pulse_o, spaced so that the 50 MHz destination never

---
 rtl/dmac_sync_pkg.sv | 17 +
 rtl/dma_event_pacer.sv | 144 ++++++++++++++
 tb/tb_dma_event_pacer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmac_sync_pkg.sv
// dmac_sync_pkg
//   Shared types and defaults for the DMAC source-side synchronisation path.
//   pacer_state_e : state encoding of dma_event_pacer
//   DEF_GAP_CYC   : default idle cycles forced after every pacer pulse
//   DEF_MAX_PEND  : default depth of the pacer event queue
package dmac_sync_pkg;

  typedef enum logic [1:0] {
    PACER_IDLE,
    PACER_FIRE,
    PACER_GAP
  } pacer_state_e;

  localparam int DEF_GAP_CYC  = 6;
  localparam int DEF_MAX_PEND = 15;

endpackage : dmac_sync_pkg

// File: rtl/dma_event_pacer.sv
// dma_event_pacer
//   Counts single-cycle event requests in the 100 MHz source domain and re-issues them
//   as single-cycle pulses spaced GAP_CYC+1 cycles apart, so a toggle-based pulse
//   synchronizer into the 50 MHz destination never loses an event.
//
//   Ports
//     src_clk_i   in   source clock
//     src_rstn_i  in   asynchronous active-low reset
//     evt_req_i   in   one event per high cycle
//     flush_i     in   synchronous clear of all queued events
//     pulse_o     out  registered one-cycle pulse to synchronizer d_in
//     pending_o   out  queued events, including the one firing
//     full_o      out  pending_o == MAX_PEND
//     busy_o      out  FSM not idle or events queued
//     ovf_clr_i   in   clear sticky overflow      (DMA_EVENT_PACER_OVF_EN only)
//     ovf_o       out  sticky full-drop overflow  (DMA_EVENT_PACER_OVF_EN only)
//
//   Build option: define DMA_EVENT_PACER_OVF_EN to add the overflow flag.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | nothing firing; leaves as soon as the queue is non-empty
//   FIRE  | pulse_o high for exactly one cycle, consumes one event
//   GAP   | GAP_CYC forced idle cycles to keep the synchronizer safe
module dma_event_pacer
  import dmac_sync_pkg::*;
#(
  parameter int  MAX_PEND = DEF_MAX_PEND,
  parameter int  GAP_CYC  = DEF_GAP_CYC,
  localparam int CNT_W    = $clog2(MAX_PEND + 1)
) (
  input  logic             src_clk_i,
  input  logic             src_rstn_i,
  input  logic             evt_req_i,
  input  logic             flush_i,
`ifdef DMA_EVENT_PACER_OVF_EN
  input  logic             ovf_clr_i,
  output logic             ovf_o,
`endif
  output logic             pulse_o,
  output logic [CNT_W-1:0] pending_o,
  output logic             full_o,
  output logic             busy_o
);

  localparam int               GAP_W    = $clog2(GAP_CYC + 1);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_PEND);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

  pacer_state_e     state_q;
  logic             pulse_q;
  logic [GAP_W-1:0] gap_q;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             full;
  logic             dec;
  logic             acc;
  logic             drop;

  assign full = (pending_q == MAX_C);
  // A flush in the FIRE cycle suppresses the decrement; the queue is cleared instead.
  assign dec  = (state_q == PACER_FIRE) && (pending_q != '0) && !flush_i;
  assign acc  = evt_req_i && !flush_i;
  // Only a request arriving while full with nothing leaving is lost.
  assign drop = acc && full && !dec;

  always_comb begin
    pending_d = pending_q;
    if (flush_i) begin
      pending_d = '0;
    end else if (acc && !dec) begin
      if (!full) pending_d = pending_q + 1'b1;
    end else if (!acc && dec) begin
      pending_d = pending_q - 1'b1;
    end
  end

  always_ff @(posedge src_clk_i or negedge src_rstn_i) begin
    if (!src_rstn_i) pending_q <= '0;
    else             pending_q <= pending_d;
  end

  // Leaving IDLE/GAP is held off during a flush so a flushed event never fires.
  always_ff @(posedge src_clk_i or negedge src_rstn_i) begin
    if (!src_rstn_i) begin
      state_q <= PACER_IDLE;
      pulse_q <= 1'b0;
      gap_q   <= '0;
    end else begin
      case (state_q)
        PACER_IDLE: begin
          pulse_q <= 1'b0;
          if ((pending_q != '0) && !flush_i) begin
            state_q <= PACER_FIRE;
            pulse_q <= 1'b1;
          end
        end
        PACER_FIRE: begin
          state_q <= PACER_GAP;
          pulse_q <= 1'b0;
          gap_q   <= GAP_LOAD;
        end
        PACER_GAP: begin
          pulse_q <= 1'b0;
          if (gap_q == '0) begin
            if ((pending_q != '0) && !flush_i) begin
              state_q <= PACER_FIRE;
              pulse_q <= 1'b1;
            end else begin
              state_q <= PACER_IDLE;
            end
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: begin
          state_q <= PACER_IDLE;
          pulse_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMA_EVENT_PACER_OVF_EN
  logic ovf_q;

  // Set wins over a same-cycle clear.
  always_ff @(posedge src_clk_i or negedge src_rstn_i) begin
    if (!src_rstn_i)    ovf_q <= 1'b0;
    else if (drop)      ovf_q <= 1'b1;
    else if (ovf_clr_i) ovf_q <= 1'b0;
  end

  assign ovf_o = ovf_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  assign pulse_o   = pulse_q;
  assign pending_o = pending_q;
  assign full_o    = full;
  assign busy_o    = (state_q != PACER_IDLE) || (pending_q != '0);

endmodule : dma_event_pacer

// File: tb/tb_dma_event_pacer.sv
// tb_dma_event_pacer
//   Directed bench for dma_event_pacer at default parameters. Stimulus pushes the
//   absolute cycle of every expected pulse into a queue; a monitor pops on each
//   observed pulse. Counter/flag values are checked at hand-computed cycles.
//   Define DMA_EVENT_PACER_OVF_EN to also check the overflow flag.
module tb_dma_event_pacer;

  logic       clk;
  logic       rstn;
  logic       evt;
  logic       flush;
  logic       pulse;
  logic [3:0] pending;
  logic       full;
  logic       busy;
`ifdef DMA_EVENT_PACER_OVF_EN
  logic       ovf_clr;
  logic       ovf;
`endif

  int gcyc;
  int base;
  int n_pass;
  int n_total;
  int exp_q[$];

  dma_event_pacer dut (
    .src_clk_i  (clk),
    .src_rstn_i (rstn),
    .evt_req_i  (evt),
    .flush_i    (flush),
`ifdef DMA_EVENT_PACER_OVF_EN
    .ovf_clr_i  (ovf_clr),
    .ovf_o      (ovf),
`endif
    .pulse_o    (pulse),
    .pending_o  (pending),
    .full_o     (full),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial gcyc = 0;
  always @(posedge clk) gcyc <= gcyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, gcyc - base);
  endtask

  // Scoreboard monitor: every pulse must match the oldest expected pulse cycle.
  always @(negedge clk) begin
    if (rstn && pulse) begin
      if (exp_q.size() == 0) begin
        chk("pulse_unexpected", gcyc - base, -1);
      end else begin
        chk("pulse_cycle", gcyc - base, exp_q.pop_front() - base);
      end
    end
  end

  // Advance to just after the posedge that starts relative cycle c.
  task automatic go(input int c);
    while (gcyc - base < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Mid-cycle sample point of relative cycle c.
  task automatic samp(input int c);
    go(c);
    #3;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn  = 1'b0;
    evt   = 1'b0;
    flush = 1'b0;
`ifdef DMA_EVENT_PACER_OVF_EN
    ovf_clr = 1'b0;
`endif
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    base = gcyc;
  endtask

  task automatic push_pulses(input int first, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(base + first + 7 * k);
  endtask

  task automatic req_range(input int from, input int to);
    for (int c = from; c <= to; c++) begin
      go(c);
      evt = 1'b1;
    end
    go(to + 1);
    evt = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    base    = 0;
    rstn    = 1'b0;
    evt     = 1'b0;
    flush   = 1'b0;
`ifdef DMA_EVENT_PACER_OVF_EN
    ovf_clr = 1'b0;
`endif
    #2;
    chk("rst_pulse", int'(pulse), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_busy", int'(busy), 0);
`ifdef DMA_EVENT_PACER_OVF_EN
    chk("rst_ovf", int'(ovf), 0);
`endif

    // 1. single request
    do_reset();
    push_pulses(12, 1);
    req_range(10, 10);
    samp(11); chk("t1_pending_11", int'(pending), 1);
    samp(12); chk("t1_pulse_12", int'(pulse), 1);
    samp(13); chk("t1_pending_13", int'(pending), 0);
              chk("t1_pulse_13", int'(pulse), 0);
    samp(18); chk("t1_busy_18", int'(busy), 1);
    samp(19); chk("t1_busy_19", int'(busy), 0);
    samp(25); chk("t1_missing", exp_q.size(), 0);

    // 2. burst of 3
    do_reset();
    push_pulses(12, 3);
    req_range(10, 12);
    samp(13); chk("t2_pending_13", int'(pending), 2);
    samp(40); chk("t2_missing", exp_q.size(), 0);
              chk("t2_busy_40", int'(busy), 0);

    // 3. saturation: 20 requests, 18 accepted
    do_reset();
    push_pulses(12, 18);
    req_range(10, 29);
    samp(30); chk("t3_pending_30", int'(pending), 15);
              chk("t3_full_30", int'(full), 1);
`ifdef DMA_EVENT_PACER_OVF_EN
    do_reset();
    push_pulses(12, 18);
    for (int c = 10; c <= 29; c++) begin
      go(c);
      evt = 1'b1;
      #3;
      if (c == 28) chk("t3_ovf_28", int'(ovf), 0);
      if (c == 29) chk("t3_ovf_29", int'(ovf), 1);
    end
    go(30);
    evt = 1'b0;
    go(35);
    ovf_clr = 1'b1;
    #3; chk("t3_ovf_35", int'(ovf), 1);
    go(36);
    ovf_clr = 1'b0;
    #3; chk("t3_ovf_cleared", int'(ovf), 0);
`endif
    samp(28 + 0 * 0 + 100); chk("t3_pending_128", int'(pending), 1);
    samp(140); chk("t3_missing", exp_q.size(), 0);
               chk("t3_busy_140", int'(busy), 0);

    // 4. full plus fire: request in a FIRE cycle while full is accepted
    do_reset();
    push_pulses(12, 19);
    req_range(10, 27);
    samp(28); chk("t4_pending_28", int'(pending), 15);
    go(33);
    evt = 1'b1;
    #3; chk("t4_pulse_33", int'(pulse), 1);
    go(34);
    evt = 1'b0;
    #3; chk("t4_pending_34", int'(pending), 15);
        chk("t4_full_34", int'(full), 1);
`ifdef DMA_EVENT_PACER_OVF_EN
        chk("t4_ovf_34", int'(ovf), 0);
`endif
    samp(41); chk("t4_pending_41", int'(pending), 14);
    samp(150); chk("t4_missing", exp_q.size(), 0);
               chk("t4_busy_150", int'(busy), 0);

    // 5. flush in a FIRE cycle, with a same-cycle request that must be dropped
    do_reset();
    push_pulses(12, 2);
    req_range(10, 14);
    samp(15); chk("t5_pending_15", int'(pending), 4);
    go(19);
    flush = 1'b1;
    evt   = 1'b1;
    #3; chk("t5_pulse_19", int'(pulse), 1);
    go(20);
    flush = 1'b0;
    evt   = 1'b0;
    #3; chk("t5_pending_20", int'(pending), 0);
        chk("t5_busy_20", int'(busy), 1);
`ifdef DMA_EVENT_PACER_OVF_EN
        chk("t5_ovf_20", int'(ovf), 0);
`endif
    samp(25); chk("t5_busy_25", int'(busy), 1);
    samp(26); chk("t5_busy_26", int'(busy), 0);
    samp(45); chk("t5_missing", exp_q.size(), 0);

    // 6. reset asserted mid-GAP with 4 queued
    do_reset();
    push_pulses(12, 1);
    req_range(10, 14);
    samp(15); chk("t6_pending_15", int'(pending), 4);
    go(16);
    rstn = 1'b0;
    #1; chk("t6_rst_pulse", int'(pulse), 0);
        chk("t6_rst_pending", int'(pending), 0);
        chk("t6_rst_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (40) @(posedge clk);
    #3;
    chk("t6_missing", exp_q.size(), 0);
    chk("t6_pending_end", int'(pending), 0);
    chk("t6_busy_end", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_dma_event_pacer
